mul_wb_pipe: RTL and testbench
==============================

// Module: mul_wb_pipe
// PURPOSE
//   Receiving end of the M1 multiply stage: carries finished products through
//   DEPTH delay stages (M2..M5) and presents them to writeback.
//   Holds and backpressures on WB refusal; supports global stall and flush.
//   Reports in-flight destination registers to decode for RAW hazards.
// PARAMETERS
//   XLEN    32  datapath width
//   REGMSB  5   register index width
//   DEPTH   4   delay stages after M1; total multiply latency = DEPTH+1
// PORTS
//   clk              in   1           clock; all state on posedge
//   reset_n          in   1           asynchronous reset, active-low
//   stall_in         in   1           global pipeline stall
//   flush_in         in   1           synchronous kill of all in-flight entries
//   valid_in         in   1           M1 holds a valid multiply
//   xcpt_in          in   xcpt_e      exception tag from M1
//   rd_in            in   REGMSB      destination register from M1
//   result_in        in   XLEN        product from M1
//   wb_ready_in      in   1           WB accepts the last-stage entry this cycle
//   valid_out        out  1           last stage valid, offered to WB
//   xcpt_out         out  xcpt_e      exception tag of the last stage
//   rd_out           out  REGMSB      destination register of the last stage
//   result_out       out  XLEN        product of the last stage
//   busy_out         out  1           pipe not advancing; M1 and upstream hold
//   query_rs1_in     in   REGMSB      decode source register 1
//   query_rs2_in     in   REGMSB      decode source register 2
//   rs1_hazard_out   out  1           rs1 must stall
//   rs2_hazard_out   out  1           rs2 must stall
//   rs1_fwd_valid_out/rs2_fwd_valid_out  out 1     forward available (feature)
//   rs1_fwd_data_out/rs2_fwd_data_out    out XLEN  forwarded product (feature)
// BEHAVIOUR
// - Stage k = 0..DEPTH-1 holds {v, xcpt, rd, result}; stage 0 youngest.
// - Reset (async, reset_n=0): all v=0, rd=0, result=0, xcpt=NO_XCPT.
//   All outputs 0 / NO_XCPT, except busy_out = stall_in (combinational).
// - advance = ~stall_in & (~v[DEPTH-1] | wb_ready_in); busy_out = ~advance.
// - Shift rule: on posedge with advance, stage k <= stage k-1 and
//   stage 0 <= {valid_in, xcpt_in, rd_in, result_in}.
//   Without advance, all stages hold and inputs are ignored.
// - Fixed shift: bubbles are not collapsed; order is strictly FIFO.
// - Entry latency: capture edge to valid_out = DEPTH-1 further edges.
// - valid_out = v[DEPTH-1] & ~flush_in. The data outputs always reflect stage DEPTH-1.
// - WB handshake: commit iff valid_out & wb_ready_in.
//   An offered entry stays stable until committed or flushed.
// - flush_in has priority over advance. On the next edge every v=0,
//   xcpt=NO_XCPT, and the input is not captured. rd/result may be left stale.
// - stall_in & wb_ready_in in the same cycle: no commit, no shift.
// - Hazard match on rsN: rsN != 0 and some stage has v=1 and rd == rsN.
//   Entries with rd=0 never match.
// CONFIGURATION
// - MUL_WB_FWD_EN defined: on a match, rsN_fwd_valid_out=1 and
//   rsN_fwd_data_out = result of the youngest matching stage (lowest k).
//   rsN_hazard_out=0, since every in-flight product is final.
// - MUL_WB_FWD_EN undefined: rsN_hazard_out=1 on a match.
//   rsN_fwd_valid_out=0, rsN_fwd_data_out=0, and no forwarding mux is built.
// TESTING
// 1. valid_in=1, rd=5, result=0x12 for one cycle, wb_ready_in=1 -> after 3 further edges,
//    valid_out=1, rd_out=5, result_out=0x12 for exactly 1 cycle.
// 2. Four back-to-back entries (rd 1..4). wb_ready_in=0 when rd=1 reaches the end ->
//    busy_out=1, all stages hold. wb_ready_in=1 -> rd 1,2,3,4 commit in order,
//    no loss and no duplicate.
// 3. Three entries in flight, flush_in=1 for one cycle -> valid_out=0 that cycle,
//    all v=0 after the edge, and no later output from the killed entries.
// 4. rd=7, result=0xABCD in stage 2, query_rs1_in=7 -> no FWD: rs1_hazard_out=1.
//    With FWD: rs1_fwd_valid_out=1, data 0xABCD, hazard 0.
//    query_rs2_in=0 against an rd=0 entry -> no hazard, no forward.
// 5. Same rd=9 in stages 0 and 3 (0x1 young, 0x2 old), FWD on -> rs1_fwd_data_out=0x1.
// 6. reset_n low mid-flight with no clock edge -> outputs 0 immediately.
//    After reset_n rises, stall_in=1 with valid_in=1 for 5 cycles -> nothing captured,
//    valid_out stays 0.

Source files
------------

// File: rtl/mul_wb_pipe_if.sv
// Exception tag type and the M1 / writeback / decode-query bundle for mul_wb_pipe.
// slave is the pipe side; master is whatever drives M1 and WB around it.
package mul_wb_pkg;
   typedef enum logic [1:0] {
      NO_XCPT       = 2'd0,
      XCPT_ILLEGAL  = 2'd1,
      XCPT_OVERFLOW = 2'd2,
      XCPT_MISC     = 2'd3
   } xcpt_e;
endpackage

interface mul_wb_if #(
   parameter int XLEN   = 32,
   parameter int REGMSB = 5
) ();
   import mul_wb_pkg::*;

   // Handshakes: M1 -> pipe captures {valid_in,..} on an edge where busy_out=0.
   // Pipe -> WB transfers the entry on an edge where valid_out & wb_ready_in.
   // An offered entry stays stable until it transfers or is flushed.
   logic              stall_in;
   logic              flush_in;
   logic              valid_in;
   xcpt_e             xcpt_in;
   logic [REGMSB-1:0] rd_in;
   logic [XLEN-1:0]   result_in;
   logic              wb_ready_in;
   logic              valid_out;
   xcpt_e             xcpt_out;
   logic [REGMSB-1:0] rd_out;
   logic [XLEN-1:0]   result_out;
   logic              busy_out;
   logic [REGMSB-1:0] query_rs1_in;
   logic [REGMSB-1:0] query_rs2_in;
   logic              rs1_hazard_out;
   logic              rs2_hazard_out;
   logic              rs1_fwd_valid_out;
   logic              rs2_fwd_valid_out;
   logic [XLEN-1:0]   rs1_fwd_data_out;
   logic [XLEN-1:0]   rs2_fwd_data_out;

   modport slave (
      input  stall_in, flush_in, valid_in, xcpt_in, rd_in, result_in, wb_ready_in,
      input  query_rs1_in, query_rs2_in,
      output valid_out, xcpt_out, rd_out, result_out, busy_out,
      output rs1_hazard_out, rs2_hazard_out,
      output rs1_fwd_valid_out, rs2_fwd_valid_out, rs1_fwd_data_out, rs2_fwd_data_out
   );

   modport master (
      output stall_in, flush_in, valid_in, xcpt_in, rd_in, result_in, wb_ready_in,
      output query_rs1_in, query_rs2_in,
      input  valid_out, xcpt_out, rd_out, result_out, busy_out,
      input  rs1_hazard_out, rs2_hazard_out,
      input  rs1_fwd_valid_out, rs2_fwd_valid_out, rs1_fwd_data_out, rs2_fwd_data_out
   );
endinterface

// File: rtl/mul_wb_pipe.sv
// Multiply delay pipe (M2..M5): fixed FIFO shift of M1 products to writeback,
// with stall/flush and RAW hazard reporting. Define MUL_WB_FWD_EN to forward instead of stalling.
module mul_wb_pipe
   import mul_wb_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REGMSB = 5,
   parameter int DEPTH  = 4
) (
   input logic     clk,
   input logic     reset_n,
   mul_wb_if.slave bus
);
   localparam int LAST = DEPTH - 1;

   // Stage 0 is youngest, stage LAST is the one offered to writeback.
   logic [DEPTH-1:0]  v_q;
   xcpt_e             xcpt_q   [DEPTH];
   logic [REGMSB-1:0] rd_q     [DEPTH];
   logic [XLEN-1:0]   result_q [DEPTH];
   logic              advance;

   assign advance      = ~bus.stall_in & (~v_q[LAST] | bus.wb_ready_in);
   assign bus.busy_out = ~advance;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            xcpt_q[k]   <= NO_XCPT;
            rd_q[k]     <= '0;
            result_q[k] <= '0;
         end
      end else if (bus.flush_in) begin
         // rd/result are left stale; nothing reads them while v=0.
         v_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            xcpt_q[k] <= NO_XCPT;
         end
      end else if (advance) begin
         for (int k = LAST; k > 0; k--) begin
            v_q[k]      <= v_q[k-1];
            xcpt_q[k]   <= xcpt_q[k-1];
            rd_q[k]     <= rd_q[k-1];
            result_q[k] <= result_q[k-1];
         end
         v_q[0]      <= bus.valid_in;
         xcpt_q[0]   <= bus.xcpt_in;
         rd_q[0]     <= bus.rd_in;
         result_q[0] <= bus.result_in;
      end
   end

   assign bus.valid_out  = v_q[LAST] & ~bus.flush_in;
   assign bus.xcpt_out   = xcpt_q[LAST];
   assign bus.rd_out     = rd_q[LAST];
   assign bus.result_out = result_q[LAST];

   // x0 is hardwired, so a zero query never matches anything.
   logic rs1_match;
   logic rs2_match;

   always_comb begin
      rs1_match = 1'b0;
      rs2_match = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (v_q[k] && (rd_q[k] == bus.query_rs1_in)) rs1_match = 1'b1;
         if (v_q[k] && (rd_q[k] == bus.query_rs2_in)) rs2_match = 1'b1;
      end
      if (bus.query_rs1_in == '0) rs1_match = 1'b0;
      if (bus.query_rs2_in == '0) rs2_match = 1'b0;
   end

`ifdef MUL_WB_FWD_EN
   logic [XLEN-1:0] rs1_fwd_data;
   logic [XLEN-1:0] rs2_fwd_data;

   // Walk oldest to youngest so the youngest matching stage wins.
   always_comb begin
      rs1_fwd_data = '0;
      rs2_fwd_data = '0;
      for (int k = LAST; k >= 0; k--) begin
         if (v_q[k] && (rd_q[k] == bus.query_rs1_in)) rs1_fwd_data = result_q[k];
         if (v_q[k] && (rd_q[k] == bus.query_rs2_in)) rs2_fwd_data = result_q[k];
      end
   end

   assign bus.rs1_hazard_out    = 1'b0;
   assign bus.rs2_hazard_out    = 1'b0;
   assign bus.rs1_fwd_valid_out = rs1_match;
   assign bus.rs2_fwd_valid_out = rs2_match;
   assign bus.rs1_fwd_data_out  = rs1_match ? rs1_fwd_data : '0;
   assign bus.rs2_fwd_data_out  = rs2_match ? rs2_fwd_data : '0;
`else
   assign bus.rs1_hazard_out    = rs1_match;
   assign bus.rs2_hazard_out    = rs2_match;
   assign bus.rs1_fwd_valid_out = 1'b0;
   assign bus.rs2_fwd_valid_out = 1'b0;
   assign bus.rs1_fwd_data_out  = '0;
   assign bus.rs2_fwd_data_out  = '0;
`endif

endmodule

// File: tb/tb_mul_wb_pipe.sv
// Directed bench for mul_wb_pipe: latency, backpressure, flush, hazard/forward, async reset.
module tb_mul_wb_pipe;
   import mul_wb_pkg::*;

   localparam int XLEN   = 32;
   localparam int REGMSB = 5;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   logic [REGMSB+XLEN-1:0] exp_q[$];

   mul_wb_if #(.XLEN(XLEN), .REGMSB(REGMSB)) bus ();

   mul_wb_pipe #(.XLEN(XLEN), .REGMSB(REGMSB), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_idle();
      bus.stall_in     = 1'b0;
      bus.flush_in     = 1'b0;
      bus.valid_in     = 1'b0;
      bus.xcpt_in      = NO_XCPT;
      bus.rd_in        = '0;
      bus.result_in    = '0;
      bus.wb_ready_in  = 1'b1;
      bus.query_rs1_in = '0;
      bus.query_rs2_in = '0;
   endtask

   task automatic drive_entry(input logic [REGMSB-1:0] rd, input logic [XLEN-1:0] res, input xcpt_e x);
      bus.valid_in  = 1'b1;
      bus.rd_in     = rd;
      bus.result_in = res;
      bus.xcpt_in   = x;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive_idle();
      #1;
      total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", bus.valid_out); end
      total++; if (bus.rd_out !== 5'd0) begin bad++; $display("FAIL reset_rd: got %0d want 0", bus.rd_out); end
      total++; if (bus.result_out !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", bus.result_out); end
      total++; if (bus.xcpt_out !== NO_XCPT) begin bad++; $display("FAIL reset_xcpt: got %0d want 0", bus.xcpt_out); end
      bus.stall_in = 1'b1;
      #1;
      total++; if (bus.busy_out !== 1'b1) begin bad++; $display("FAIL reset_busy_stall: got %0b want 1", bus.busy_out); end
      bus.stall_in = 1'b0;
      #1;
      total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy_idle: got %0b want 0", bus.busy_out); end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_latency();
      drive_entry(5'd5, 32'h12, NO_XCPT);
      tick();
      bus.valid_in = 1'b0;
      total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL lat_edge0: got %0b want 0", bus.valid_out); end
      for (int i = 1; i <= 2; i++) begin
         tick();
         total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL lat_edge%0d: got %0b want 0", i, bus.valid_out); end
      end
      tick();
      total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL lat_valid: got %0b want 1", bus.valid_out); end
      total++; if (bus.rd_out !== 5'd5) begin bad++; $display("FAIL lat_rd: got %0d want 5", bus.rd_out); end
      total++; if (bus.result_out !== 32'h12) begin bad++; $display("FAIL lat_result: got %h want 12", bus.result_out); end
      tick();
      total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL lat_one_cycle: got %0b want 0", bus.valid_out); end
   endtask

   task automatic test_back_to_back();
      logic [REGMSB+XLEN-1:0] exp;
      logic [REGMSB-1:0]      r;
      int                     commits;
      for (int i = 1; i <= 4; i++) begin
         r = i[REGMSB-1:0];
         drive_entry(r, 32'h100 + i, NO_XCPT);
         exp_q.push_back({r, 32'h100 + i});
         tick();
      end
      // Held entry must ignore this input.
      drive_entry(5'd31, 32'hDEAD, XCPT_MISC);
      bus.wb_ready_in = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         total++; if (bus.busy_out !== 1'b1) begin bad++; $display("FAIL b2b_busy%0d: got %0b want 1", c, bus.busy_out); end
         total++; if (bus.valid_out !== 1'b1 || bus.rd_out !== 5'd1) begin bad++; $display("FAIL b2b_hold%0d: got v=%0b rd=%0d want v=1 rd=1", c, bus.valid_out, bus.rd_out); end
         tick();
      end
      bus.valid_in    = 1'b0;
      bus.wb_ready_in = 1'b1;
      bus.stall_in    = 1'b1;
      #1;
      total++; if (bus.busy_out !== 1'b1) begin bad++; $display("FAIL b2b_stall_busy: got %0b want 1", bus.busy_out); end
      tick();
      total++; if (bus.valid_out !== 1'b1 || bus.rd_out !== 5'd1) begin bad++; $display("FAIL b2b_stall_nocommit: got v=%0b rd=%0d want v=1 rd=1", bus.valid_out, bus.rd_out); end
      bus.stall_in = 1'b0;
      #1;
      total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL b2b_release_busy: got %0b want 0", bus.busy_out); end
      commits = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus.valid_out && bus.wb_ready_in) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL b2b_extra: got rd=%0d want no commit", bus.rd_out);
            end else begin
               exp = exp_q.pop_front();
               if ({bus.rd_out, bus.result_out} !== exp) begin
                  bad++; $display("FAIL b2b_order: got %h want %h", {bus.rd_out, bus.result_out}, exp);
               end
            end
            commits++;
         end
         tick();
      end
      total++; if (commits != 4 || exp_q.size() != 0) begin bad++; $display("FAIL b2b_count: got %0d commits want 4 (left %0d)", commits, exp_q.size()); end
   endtask

   task automatic test_flush();
      drive_entry(5'd10, 32'hA0, XCPT_ILLEGAL);
      tick();
      drive_entry(5'd11, 32'hB0, NO_XCPT);
      tick();
      drive_entry(5'd12, 32'hC0, XCPT_OVERFLOW);
      tick();
      bus.valid_in = 1'b0;
      tick();
      total++; if (bus.valid_out !== 1'b1 || bus.rd_out !== 5'd10) begin bad++; $display("FAIL flush_pre: got v=%0b rd=%0d want v=1 rd=10", bus.valid_out, bus.rd_out); end
      total++; if (bus.xcpt_out !== XCPT_ILLEGAL) begin bad++; $display("FAIL flush_xcpt_tag: got %0d want 1", bus.xcpt_out); end
      bus.flush_in = 1'b1;
      drive_entry(5'd13, 32'hD0, NO_XCPT);
      #1;
      total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL flush_valid_now: got %0b want 0", bus.valid_out); end
      tick();
      bus.flush_in = 1'b0;
      bus.valid_in = 1'b0;
      total++; if (dut.v_q !== 4'b0000) begin bad++; $display("FAIL flush_v_cleared: got %b want 0000", dut.v_q); end
      total++; if (bus.xcpt_out !== NO_XCPT) begin bad++; $display("FAIL flush_xcpt_cleared: got %0d want 0", bus.xcpt_out); end
      for (int c = 0; c < 6; c++) begin
         tick();
         total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL flush_killed%0d: got %0b want 0", c, bus.valid_out); end
      end
   endtask

   task automatic test_hazard();
      drive_entry(5'd7, 32'hABCD, NO_XCPT);
      tick();
      drive_entry(5'd0, 32'h55, NO_XCPT);
      tick();
      bus.valid_in = 1'b0;
      tick();
      bus.stall_in     = 1'b1;
      bus.query_rs1_in = 5'd7;
      bus.query_rs2_in = 5'd0;
      #1;
`ifdef MUL_WB_FWD_EN
      total++; if (bus.rs1_fwd_valid_out !== 1'b1 || bus.rs1_fwd_data_out !== 32'hABCD) begin bad++; $display("FAIL hz_rs1_fwd: got v=%0b d=%h want v=1 d=abcd", bus.rs1_fwd_valid_out, bus.rs1_fwd_data_out); end
      total++; if (bus.rs1_hazard_out !== 1'b0) begin bad++; $display("FAIL hz_rs1_nohaz: got %0b want 0", bus.rs1_hazard_out); end
`else
      total++; if (bus.rs1_hazard_out !== 1'b1) begin bad++; $display("FAIL hz_rs1_haz: got %0b want 1", bus.rs1_hazard_out); end
      total++; if (bus.rs1_fwd_valid_out !== 1'b0 || bus.rs1_fwd_data_out !== 32'd0) begin bad++; $display("FAIL hz_rs1_nofwd: got v=%0b d=%h want 0 0", bus.rs1_fwd_valid_out, bus.rs1_fwd_data_out); end
`endif
      total++; if (bus.rs2_hazard_out !== 1'b0 || bus.rs2_fwd_valid_out !== 1'b0) begin bad++; $display("FAIL hz_rs2_zero: got h=%0b f=%0b want 0 0", bus.rs2_hazard_out, bus.rs2_fwd_valid_out); end
      bus.query_rs2_in = 5'd8;
      #1;
      total++; if (bus.rs2_hazard_out !== 1'b0 || bus.rs2_fwd_valid_out !== 1'b0) begin bad++; $display("FAIL hz_rs2_nomatch: got h=%0b f=%0b want 0 0", bus.rs2_hazard_out, bus.rs2_fwd_valid_out); end
      bus.query_rs2_in = 5'd7;
      #1;
`ifdef MUL_WB_FWD_EN
      total++; if (bus.rs2_fwd_valid_out !== 1'b1 || bus.rs2_fwd_data_out !== 32'hABCD) begin bad++; $display("FAIL hz_rs2_fwd: got v=%0b d=%h want v=1 d=abcd", bus.rs2_fwd_valid_out, bus.rs2_fwd_data_out); end
`else
      total++; if (bus.rs2_hazard_out !== 1'b1) begin bad++; $display("FAIL hz_rs2_haz: got %0b want 1", bus.rs2_hazard_out); end
`endif
      bus.flush_in = 1'b1;
      tick();
      drive_idle();
   endtask

   task automatic test_youngest();
      drive_entry(5'd9, 32'h2, NO_XCPT);
      tick();
      bus.valid_in = 1'b0;
      tick();
      tick();
      drive_entry(5'd9, 32'h1, NO_XCPT);
      tick();
      bus.valid_in     = 1'b0;
      bus.stall_in     = 1'b1;
      bus.query_rs1_in = 5'd9;
      #1;
      total++; if (bus.valid_out !== 1'b1 || bus.result_out !== 32'h2) begin bad++; $display("FAIL young_last: got v=%0b r=%h want v=1 r=2", bus.valid_out, bus.result_out); end
`ifdef MUL_WB_FWD_EN
      total++; if (bus.rs1_fwd_valid_out !== 1'b1 || bus.rs1_fwd_data_out !== 32'h1) begin bad++; $display("FAIL young_fwd: got v=%0b d=%h want v=1 d=1", bus.rs1_fwd_valid_out, bus.rs1_fwd_data_out); end
`else
      total++; if (bus.rs1_hazard_out !== 1'b1 || bus.rs1_fwd_data_out !== 32'd0) begin bad++; $display("FAIL young_haz: got h=%0b d=%h want h=1 d=0", bus.rs1_hazard_out, bus.rs1_fwd_data_out); end
`endif
      bus.flush_in = 1'b1;
      tick();
      drive_idle();
   endtask

   task automatic test_async_reset();
      drive_entry(5'd3, 32'h33, XCPT_MISC);
      for (int c = 0; c < 4; c++) tick();
      bus.valid_in     = 1'b0;
      bus.query_rs1_in = 5'd3;
      #1;
      total++; if (bus.valid_out !== 1'b1 || bus.rd_out !== 5'd3) begin bad++; $display("FAIL ar_pre: got v=%0b rd=%0d want v=1 rd=3", bus.valid_out, bus.rd_out); end
      #1;
      reset_n = 1'b0;
      #1;
      total++; if (bus.valid_out !== 1'b0 || bus.rd_out !== 5'd0 || bus.result_out !== 32'd0) begin bad++; $display("FAIL ar_out: got v=%0b rd=%0d r=%h want 0 0 0", bus.valid_out, bus.rd_out, bus.result_out); end
      total++; if (bus.xcpt_out !== NO_XCPT) begin bad++; $display("FAIL ar_xcpt: got %0d want 0", bus.xcpt_out); end
      total++; if (bus.rs1_hazard_out !== 1'b0 || bus.rs1_fwd_valid_out !== 1'b0) begin bad++; $display("FAIL ar_hazard: got h=%0b f=%0b want 0 0", bus.rs1_hazard_out, bus.rs1_fwd_valid_out); end
      #1;
      reset_n = 1'b1;
      bus.stall_in = 1'b1;
      drive_entry(5'd4, 32'h44, NO_XCPT);
      for (int c = 0; c < 5; c++) begin
         tick();
         total++; if (bus.valid_out !== 1'b0 || bus.busy_out !== 1'b1) begin bad++; $display("FAIL ar_stall%0d: got v=%0b busy=%0b want v=0 busy=1", c, bus.valid_out, bus.busy_out); end
      end
      total++; if (dut.v_q !== 4'b0000) begin bad++; $display("FAIL ar_nocapture: got %b want 0000", dut.v_q); end
      bus.stall_in = 1'b0;
      bus.valid_in = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL ar_drain%0d: got %0b want 0", c, bus.valid_out); end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_flush();
      test_hazard();
      test_youngest();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
